// File: rtl/branch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// branch_ctrl_pkg
// Shared definitions for the ID-stage branch sequencing controller:
//   - branch class codes as presented on id_br_type / driven on cmp_op
//   - comparator idle op code
//   - controller FSM state encoding
//   - default statistics counter width
// ---------------------------------------------------------------------------
package branch_ctrl_pkg;

    localparam int CNT_W_DEF = 32;

    localparam logic [2:0] BR_LTZ  = 3'd0;
    localparam logic [2:0] BR_LEZ  = 3'd1;
    localparam logic [2:0] BR_GTZ  = 3'd2;
    localparam logic [2:0] BR_GEZ  = 3'd3;
    localparam logic [2:0] BR_EQ   = 3'd4;
    localparam logic [2:0] BR_NE   = 3'd5;
    localparam logic [2:0] BR_NONE = 3'd6;

    localparam logic [2:0] CMP_NOP = 3'b110;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } br_state_e;

    // Two-operand compares (BEQ/BNE) read rt as well as rs.
    function automatic logic br_uses_rt(input logic [2:0] br_type);
        return (br_type == BR_EQ) || (br_type == BR_NE);
    endfunction

endpackage

// File: rtl/branch_ctrl_br_hazard_det.sv
// ---------------------------------------------------------------------------
// br_hazard_det
// Combinational operand-readiness calculator for the ID branch comparator.
// Returns how many cycles the branch must wait before both of its operands
// can be forwarded into ID.
//   use_rs, use_rt          : which source operands the branch reads
//   rs, rt                  : source register numbers
//   ex_wr_en/is_load/addr   : instruction currently in EX
//   mem_wr_en/is_load/addr  : instruction currently in MEM
//   need                    : 0, 1 or 2 wait cycles (max over used operands)
// ---------------------------------------------------------------------------
module br_hazard_det
    import branch_ctrl_pkg::*;
(
    input  logic       use_rs,
    input  logic       use_rt,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       ex_wr_en,
    input  logic       ex_is_load,
    input  logic [4:0] ex_wr_addr,
    input  logic       mem_wr_en,
    input  logic       mem_is_load,
    input  logic [4:0] mem_wr_addr,
    output logic [1:0] need
);

    logic [1:0] need_rs;
    logic [1:0] need_rt;

    // A load in EX has its data two cycles away; an ALU result in EX or a
    // load in MEM becomes forwardable next cycle. $0 is hardwired and never
    // creates a dependency.
    function automatic logic [1:0] op_need(
        input logic [4:0] r,
        input logic       exw,
        input logic       exl,
        input logic [4:0] exa,
        input logic       memw,
        input logic       meml,
        input logic [4:0] mema
    );
        logic [1:0] n;
        n = 2'd0;
        if (r != 5'd0) begin
            if (exw && (exa == r)) begin
                n = exl ? 2'd2 : 2'd1;
            end else if (memw && meml && (mema == r)) begin
                n = 2'd1;
            end
        end
        return n;
    endfunction

    always_comb begin
        need_rs = 2'd0;
        need_rt = 2'd0;
        if (use_rs) begin
            need_rs = op_need(rs, ex_wr_en, ex_is_load, ex_wr_addr,
                              mem_wr_en, mem_is_load, mem_wr_addr);
        end
        if (use_rt) begin
            need_rt = op_need(rt, ex_wr_en, ex_is_load, ex_wr_addr,
                              mem_wr_en, mem_is_load, mem_wr_addr);
        end
        need = (need_rs > need_rt) ? need_rs : need_rt;
    end

endmodule

// File: rtl/branch_ctrl.sv
// ---------------------------------------------------------------------------
// branch_ctrl
// Sequencing controller for the ID-stage branch comparator of the 5-stage
// MIPS pipeline. Decodes the branch class in ID, drives the comparator op,
// stalls IF/ID until the operands are forwardable, then samples cmp_br and
// raises the PC redirect. Keeps saturating branch statistics.
//   clk, reset (sync, active-low)
//   id_valid, id_br_type, id_rs, id_rt     : instruction in ID
//   ex_*, mem_*                             : downstream writer info
//   flush                                   : kill of the ID instruction
//   cmp_br                                  : comparator result for cmp_op
//   cmp_op, stall, redirect                 : control outputs
//   br_cnt, taken_cnt, stall_cnt            : statistics (saturating)
// The branch delay slot is already fetched at resolve time and is left alone.
// ---------------------------------------------------------------------------
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int MAX_STALL = 2
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [2:0]       id_br_type,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_wr_en,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_wr_addr,
    input  logic             mem_wr_en,
    input  logic             mem_is_load,
    input  logic [4:0]       mem_wr_addr,
    input  logic             flush,
    input  logic             cmp_br,
    output logic [2:0]       cmp_op,
    output logic             stall,
    output logic             redirect,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = $clog2(MAX_STALL + 1);

    br_state_e         state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic       is_br;
    logic       use_rt;
    logic [1:0] need;
    logic       br_inc;
    logic       taken_inc;
    logic       stall_inc;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v,
        input logic             en
    );
        return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
    endfunction

    assign is_br  = id_valid && (id_br_type <= BR_NE);
    assign use_rt = is_br && br_uses_rt(id_br_type);

    br_hazard_det u_hazard (
        .use_rs      (is_br),
        .use_rt      (use_rt),
        .rs          (id_rs),
        .rt          (id_rt),
        .ex_wr_en    (ex_wr_en),
        .ex_is_load  (ex_is_load),
        .ex_wr_addr  (ex_wr_addr),
        .mem_wr_en   (mem_wr_en),
        .mem_is_load (mem_is_load),
        .mem_wr_addr (mem_wr_addr),
        .need        (need)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        stall      = 1'b0;
        redirect   = 1'b0;
        cmp_op     = is_br ? id_br_type : CMP_NOP;
        br_inc     = 1'b0;
        taken_inc  = 1'b0;
        stall_inc  = 1'b0;

        if (flush) begin
            state_d    = ST_IDLE;
            wait_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (is_br) begin
                        if (need == 2'd0) begin
                            redirect  = cmp_br;
                            br_inc    = 1'b1;
                            taken_inc = cmp_br;
                        end else begin
                            // need = 1 clears by itself next cycle, so only
                            // the load-in-EX case parks in WAIT.
                            stall      = 1'b1;
                            stall_inc  = 1'b1;
                            wait_cnt_d = WAIT_W'(need - 2'd1);
                            if (need == 2'(MAX_STALL)) begin
                                state_d = ST_WAIT;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    stall     = 1'b1;
                    stall_inc = 1'b1;
                    // Leave as the count drains so the branch re-evaluates
                    // in IDLE on the very next cycle.
                    if (wait_cnt_q <= WAIT_W'(1)) begin
                        state_d    = ST_IDLE;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = '0;
                end
            endcase
        end

        br_cnt_d    = sat_inc(br_cnt_q, br_inc);
        taken_cnt_d = sat_inc(taken_cnt_q, taken_inc);
        stall_cnt_d = sat_inc(stall_cnt_q, stall_inc);

        if (!reset) begin
            stall    = 1'b0;
            redirect = 1'b0;
            cmp_op   = CMP_NOP;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign br_cnt    = br_cnt_q;
    assign taken_cnt = taken_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_ctrl
// Self-checking bench for branch_ctrl. A 32-bit instance and a 4-bit counter
// instance share all inputs; the narrow one makes counter saturation
// reachable. Expected values come from a cycle-level behavioural model.
// ---------------------------------------------------------------------------
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [2:0]  id_br_type;
    logic [4:0]  id_rs, id_rt;
    logic        ex_wr_en, ex_is_load;
    logic [4:0]  ex_wr_addr;
    logic        mem_wr_en, mem_is_load;
    logic [4:0]  mem_wr_addr;
    logic        flush;
    logic        cmp_br;

    logic [2:0]  cmp_op,   s_cmp_op;
    logic        stall,    s_stall;
    logic        redirect, s_redirect;
    logic [31:0] br_cnt, taken_cnt, stall_cnt;
    logic [3:0]  s_br_cnt, s_taken_cnt, s_stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    int     m_wait;
    longint m_br, m_tk, m_st;
    longint n_br, n_tk, n_st;

    always #5 clk = ~clk;

    branch_ctrl #(.CNT_W(32), .MAX_STALL(2)) u_dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_br_type(id_br_type),
        .id_rs(id_rs), .id_rt(id_rt), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
        .ex_wr_addr(ex_wr_addr), .mem_wr_en(mem_wr_en), .mem_is_load(mem_is_load),
        .mem_wr_addr(mem_wr_addr), .flush(flush), .cmp_br(cmp_br),
        .cmp_op(cmp_op), .stall(stall), .redirect(redirect),
        .br_cnt(br_cnt), .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
    );

    branch_ctrl #(.CNT_W(4), .MAX_STALL(2)) u_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_br_type(id_br_type),
        .id_rs(id_rs), .id_rt(id_rt), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
        .ex_wr_addr(ex_wr_addr), .mem_wr_en(mem_wr_en), .mem_is_load(mem_is_load),
        .mem_wr_addr(mem_wr_addr), .flush(flush), .cmp_br(cmp_br),
        .cmp_op(s_cmp_op), .stall(s_stall), .redirect(s_redirect),
        .br_cnt(s_br_cnt), .taken_cnt(s_taken_cnt), .stall_cnt(s_stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint sat(input longint v, input longint cap);
        return (v < cap) ? v + 1 : v;
    endfunction

    // Cycles until every operand the branch reads can be forwarded:
    // the worst latency over all in-flight producers of those registers.
    function automatic int model_need();
        int srcs[$];
        int lat;
        lat = 0;
        srcs.push_back(int'(id_rs));
        if (id_br_type == 3'd4 || id_br_type == 3'd5) srcs.push_back(int'(id_rt));
        foreach (srcs[i]) begin
            if (srcs[i] != 0) begin
                if (ex_wr_en && int'(ex_wr_addr) == srcs[i])
                    lat = (ex_is_load && lat < 2) ? 2 : ((lat < 1) ? 1 : lat);
                if (mem_wr_en && mem_is_load && int'(mem_wr_addr) == srcs[i] && lat < 1)
                    lat = 1;
            end
        end
        return lat;
    endfunction

    task automatic set_in(input bit v, input int t, input int rs, input int rt,
                          input bit exw, input bit exl, input int exa,
                          input bit mw, input bit ml, input int ma,
                          input bit fl, input bit cb);
        id_valid = v; id_br_type = 3'(t); id_rs = 5'(rs); id_rt = 5'(rt);
        ex_wr_en = exw; ex_is_load = exl; ex_wr_addr = 5'(exa);
        mem_wr_en = mw; mem_is_load = ml; mem_wr_addr = 5'(ma);
        flush = fl; cmp_br = cb;
    endtask

    // Called at posedge+1 with inputs driven; checks at posedge+5, then
    // advances the model and returns at the next posedge+1.
    task automatic step();
        bit       is_br, e_stall, e_red, inc_br, inc_tk, inc_st;
        logic [2:0] e_op;
        int       need;
        #4;
        is_br   = id_valid && (id_br_type <= 3'd5);
        e_stall = 0; e_red = 0; inc_br = 0; inc_tk = 0; inc_st = 0;
        e_op    = is_br ? id_br_type : 3'b110;
        if (reset) begin
            if (flush) begin
                m_wait = 0;
            end else if (m_wait > 0) begin
                e_stall = 1; inc_st = 1; m_wait--;
            end else if (is_br) begin
                need = model_need();
                if (need == 0) begin
                    e_red = cmp_br; inc_br = 1; inc_tk = cmp_br;
                end else begin
                    e_stall = 1; inc_st = 1; m_wait = need - 1;
                end
            end
        end else begin
            e_op = 3'b110;
        end
        check("stall",      stall,       e_stall);
        check("redirect",   redirect,    e_red);
        check("cmp_op",     cmp_op,      e_op);
        check("br_cnt",     br_cnt,      m_br);
        check("taken_cnt",  taken_cnt,   m_tk);
        check("stall_cnt",  stall_cnt,   m_st);
        check("sat_stall",  s_stall,     e_stall);
        check("sat_br",     s_br_cnt,    n_br);
        check("sat_taken",  s_taken_cnt, n_tk);
        check("sat_stallc", s_stall_cnt, n_st);
        if (!reset) begin
            m_wait = 0; m_br = 0; m_tk = 0; m_st = 0; n_br = 0; n_tk = 0; n_st = 0;
        end else begin
            if (inc_br) begin m_br = sat(m_br, 64'hFFFF_FFFF); n_br = sat(n_br, 15); end
            if (inc_tk) begin m_tk = sat(m_tk, 64'hFFFF_FFFF); n_tk = sat(n_tk, 15); end
            if (inc_st) begin m_st = sat(m_st, 64'hFFFF_FFFF); n_st = sat(n_st, 15); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        m_wait = 0; m_br = 0; m_tk = 0; m_st = 0; n_br = 0; n_tk = 0; n_st = 0;
        reset = 1'b0;
        set_in(0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        do_reset();

        // 1: BEQ, no hazard, taken
        set_in(1, 4, 3, 4, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        check("p1_br_cnt", br_cnt, 1);
        check("p1_taken",  taken_cnt, 1);

        // 2: BNE rs=5, ALU write to $5 in EX, then bubble
        do_reset();
        set_in(1, 5, 5, 9, 1, 0, 5, 0, 0, 0, 0, 1);
        step();
        set_in(1, 5, 5, 9, 0, 0, 0, 1, 0, 5, 0, 1);
        step();
        check("p2_stall_cnt", stall_cnt, 1);
        check("p2_br_cnt",    br_cnt, 1);

        // 3: BGTZ rs=7, load to $7 in EX: two stall cycles then resolve
        do_reset();
        set_in(1, 2, 7, 0, 1, 1, 7, 0, 0, 0, 0, 0);
        step();
        set_in(1, 2, 7, 0, 0, 0, 0, 1, 1, 7, 0, 0);
        step();
        set_in(1, 2, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        check("p3_stall_cnt", stall_cnt, 2);
        check("p3_br_cnt",    br_cnt, 1);

        // 4: BEQ $0,$0 with load to $0 in EX: no stall
        do_reset();
        set_in(1, 4, 0, 0, 1, 1, 0, 1, 1, 0, 0, 1);
        step();
        check("p4_stall_cnt", stall_cnt, 0);

        // 5: flush in the middle of the load wait
        do_reset();
        set_in(1, 2, 7, 0, 1, 1, 7, 0, 0, 0, 0, 0);
        step();
        set_in(1, 2, 7, 0, 0, 0, 0, 1, 1, 7, 1, 1);
        step();
        check("p5_br_cnt", br_cnt, 0);
        set_in(0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // 6: saturate the narrow taken counter, then reset clears everything
        do_reset();
        for (int i = 0; i < 18; i++) begin
            set_in(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            step();
        end
        check("p6_sat_taken", s_taken_cnt, 4'hF);
        check("p6_br_cnt",    br_cnt, 18);
        do_reset();
        check("p6_rst_br",    br_cnt, 0);
        check("p6_rst_taken", taken_cnt, 0);
        check("p6_rst_stall", stall_cnt, 0);

        // Random traffic with small register numbers to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) != 0);
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 7),
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 15) == 0, $urandom_range(0, 1));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
